// File: rtl/my_adcip_pkg.sv
`default_nettype none
// ============================================================================
// Module   : my_adcip_pkg
// Purpose  : Shared types and constants for the ADC IP S00_AXI register file.
//            Provides the write/read FSM state encodings, register indices,
//            the AXI OKAY response code and a byte-strobe merge helper.
// Revision : 1.0 - initial release
// ============================================================================
package my_adcip_pkg;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_ACCEPT = 2'd1,
        W_RESP   = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_ACCEPT = 2'd1,
        R_DATA   = 2'd2
    } rd_state_t;

    localparam int NUM_REGS = 4;
    localparam int REG0_IDX = 0;
    localparam int REG1_IDX = 1;
    localparam int REG2_IDX = 2;
    localparam int REG3_IDX = 3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Byte lane k takes the new data when strobe bit k is set, otherwise
    // keeps the old register contents.
    function automatic logic [31:0] strb_merge(
        input logic [31:0] i_old,
        input logic [31:0] i_new,
        input logic [3:0]  i_strb
    );
        logic [31:0] v_res;
        v_res = i_old;
        for (int k = 0; k < 4; k++) begin
            if (i_strb[k]) begin
                v_res[8*k +: 8] = i_new[8*k +: 8];
            end
        end
        return v_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/my_adcip_s00_axi_regs.sv
`default_nettype none
// ============================================================================
// Module   : my_adcip_s00_axi_regs
// Purpose  : AXI4-Lite slave register file for the ADC IP S00_AXI port.
//            Four 32-bit R/W registers decoded on address bits [3:2], byte
//            strobes honoured, OKAY responses only. Register contents and
//            one-cycle per-register write pulses go to the ADC datapath.
// Ports    : S_AXI_ACLK / S_AXI_ARESETN  - clock, async active-low reset
//            S_AXI_AW* / S_AXI_W* / S_AXI_B* - write address, data, response
//            S_AXI_AR* / S_AXI_R*            - read address, data
//            regs_o   - packed register contents, reg n at [32n+31:32n]
//            reg_wr_o - one-cycle write pulse, bit n for reg n
// Revision : 1.0 - initial release
// ============================================================================
module my_adcip_s00_axi_regs
    import my_adcip_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]                    reg_wr_o
);

    wr_state_t                      r_wr_state;
    rd_state_t                      r_rd_state;
    logic [C_S_AXI_DATA_WIDTH-1:0]  r_regs [NUM_REGS];
    logic                           r_awready;
    logic                           r_wready;
    logic                           r_bvalid;
    logic                           r_arready;
    logic                           r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0]  r_rdata;
    logic [NUM_REGS-1:0]            r_reg_wr;

    logic [1:0]                     w_wr_idx;
    logic [1:0]                     w_rd_idx;
    logic                           w_unused_ok;

    // Only bits [3:2] select a register; everything else aliases.
    assign w_wr_idx = S_AXI_AWADDR[3:2];
    assign w_rd_idx = S_AXI_ARADDR[3:2];

    // Protection bits and the non-decoded address bits are intentionally ignored.
    assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    // ------------------------------------------------------------------------
    // Write FSM. Both AW and W must be valid together before either is
    // accepted; the data and address are consumed at the end of W_ACCEPT,
    // which is the cycle in which AWREADY/WREADY are high.
    // ------------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_reg_wr   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_reg_wr <= '0;
            case (r_wr_state)
                W_IDLE: begin
                    if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        r_wr_state <= W_ACCEPT;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                    end
                end
                W_ACCEPT: begin
                    r_regs[w_wr_idx]   <= strb_merge(r_regs[w_wr_idx], S_AXI_WDATA, S_AXI_WSTRB);
                    r_reg_wr[w_wr_idx] <= 1'b1;
                    r_awready          <= 1'b0;
                    r_wready           <= 1'b0;
                    r_bvalid           <= 1'b1;
                    r_wr_state         <= W_RESP;
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_bvalid   <= 1'b0;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: begin
                    r_awready  <= 1'b0;
                    r_wready   <= 1'b0;
                    r_bvalid   <= 1'b0;
                    r_wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Read FSM. RDATA is sampled from the register array at the end of
    // R_ACCEPT; because the write FSM updates the array with a non-blocking
    // assignment on the same edge, a coincident write is not visible to this
    // read (the pre-write value is returned).
    // ------------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        r_rd_state <= R_ACCEPT;
                        r_arready  <= 1'b1;
                    end
                end
                R_ACCEPT: begin
                    r_rdata    <= r_regs[w_rd_idx];
                    r_arready  <= 1'b0;
                    r_rvalid   <= 1'b1;
                    r_rd_state <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_rvalid   <= 1'b0;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: begin
                    r_arready  <= 1'b0;
                    r_rvalid   <= 1'b0;
                    r_rd_state <= R_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
            assign regs_o[g*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = r_regs[g];
        end
    endgenerate

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign reg_wr_o      = r_reg_wr;

endmodule
`default_nettype wire

// File: tb/tb_my_adcip_s00_axi_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_my_adcip_s00_axi_regs
// Purpose  : Directed self-checking bench for the S00_AXI register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_my_adcip_s00_axi_regs;

    logic         clk;
    logic         rst_n;
    logic [3:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [3:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] regs;
    logic [3:0]   reg_wr;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] wr_log [$];

    my_adcip_s00_axi_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) u_dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .regs_o        (regs),
        .reg_wr_o      (reg_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every non-zero write pulse pattern, sampled mid-cycle.
    always @(negedge clk) begin
        if (reg_wr !== 4'b0000) wr_log.push_back(reg_wr);
    end

    // ---------------- bounded waits (sampled on the falling edge) ----------
    task automatic wait_awready(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready === 1'b1) break;
        end
        n_checks++;
        if (awready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s awready timeout got %b exp 1", name, awready);
        end
    endtask

    task automatic wait_bvalid(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bvalid === 1'b1) break;
        end
        n_checks++;
        if (bvalid !== 1'b1) begin
            n_errors++;
            $display("FAIL %s bvalid timeout got %b exp 1", name, bvalid);
        end
    endtask

    task automatic wait_arready(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready === 1'b1) break;
        end
        n_checks++;
        if (arready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s arready timeout got %b exp 1", name, arready);
        end
    endtask

    task automatic wait_rvalid(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid === 1'b1) break;
        end
        n_checks++;
        if (rvalid !== 1'b1) begin
            n_errors++;
            $display("FAIL %s rvalid timeout got %b exp 1", name, rvalid);
        end
    endtask

    // ---------------- bus master transactions ------------------------------
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        @(posedge clk); #1;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        wait_awready("wr");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        wait_bvalid("wr");
        resp = bvalid ? bresp : 2'bxx;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1;
        wait_arready("rd");
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        wait_rvalid("rd");
        data = rvalid ? rdata : 32'hxxxxxxxx;
        resp = rvalid ? rresp : 2'bxx;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    // ---------------- scenarios --------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
        wvalid = 1'b0; bready = 1'b0; araddr = '0; arprot = '0;
        arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (regs !== 128'h0) begin
            n_errors++; $display("FAIL reset_regs got %h exp 0", regs);
        end
        n_checks++;
        if ({awready, wready, bvalid, arready, rvalid, reg_wr} !== 9'h0) begin
            n_errors++;
            $display("FAIL reset_hs got %b exp 0", {awready, wready, bvalid, arready, rvalid, reg_wr});
        end
        n_checks++;
        if ({rdata, bresp, rresp} !== 36'h0) begin
            n_errors++; $display("FAIL reset_data got %h exp 0", {rdata, bresp, rresp});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [1:0]  resp;
        logic [31:0] d;
        logic [3:0]  exp_log [4];
        exp_log = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        wr_log.delete();
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i*4), 32'(i+1), 4'hF, resp);
            n_checks++;
            if (resp !== 2'b00) begin
                n_errors++; $display("FAIL basic_bresp%0d got %b exp 00", i, resp);
            end
        end
        n_checks++;
        if (wr_log.size() != 4) begin
            n_errors++; $display("FAIL basic_wr_count got %0d exp 4", wr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wr_log[i] !== exp_log[i]) begin
                    n_errors++; $display("FAIL basic_wr_pulse%0d got %b exp %b", i, wr_log[i], exp_log[i]);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i*4), d, resp);
            n_checks++;
            if (d !== 32'(i+1) || resp !== 2'b00) begin
                n_errors++;
                $display("FAIL basic_read%0d got %h/%b exp %h/00", i, d, resp, 32'(i+1));
            end
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  resp;
        logic [31:0] d;
        axi_write(4'h4, 32'hFFFFFFFF, 4'hF, resp);
        axi_write(4'h4, 32'h12345678, 4'b0101, resp);
        axi_read(4'h4, d, resp);
        n_checks++;
        if (d !== 32'hFF34FF78) begin
            n_errors++; $display("FAIL strobe_read got %h exp ff34ff78", d);
        end
        n_checks++;
        if (regs[63:32] !== 32'hFF34FF78) begin
            n_errors++; $display("FAIL strobe_regs got %h exp ff34ff78", regs[63:32]);
        end
    endtask

    task automatic test_aw_early();
        wr_log.delete();
        @(posedge clk); #1;
        awaddr = 4'hC; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (awready !== 1'b0 || wready !== 1'b0) begin
                n_errors++; $display("FAIL aw_early_ready%0d got %b%b exp 00", i, awready, wready);
            end
        end
        @(posedge clk); #1;
        wvalid = 1'b1;
        wait_awready("aw_early");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        wait_bvalid("aw_early");
        @(posedge clk); #1;
        bready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_log.size() != 1 || regs[127:96] !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL aw_early_once got %0d writes reg3 %h exp 1 deadbeef", wr_log.size(), regs[127:96]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0;
        // Write channel: response held while a second write is pending.
        @(posedge clk); #1;
        awaddr = 4'h0; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        wait_awready("bp_w1");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_bvalid("bp_w1");
        awaddr = 4'h4; wdata = 32'h11111111; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0) begin
                n_errors++; $display("FAIL bp_bhold%0d got bv %b aw %b exp 1 0", i, bvalid, awready);
            end
        end
        @(posedge clk); #1; bready = 1'b1;
        @(posedge clk); #1; bready = 1'b0;
        wait_awready("bp_w2");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        wait_bvalid("bp_w2");
        @(posedge clk); #1; bready = 1'b0;
        n_checks++;
        if (regs[63:0] !== 64'h11111111_CAFEF00D) begin
            n_errors++; $display("FAIL bp_wregs got %h exp 11111111cafef00d", regs[63:0]);
        end
        // Read channel: data held while a second read is pending.
        @(posedge clk); #1;
        araddr = 4'h0; arvalid = 1'b1;
        wait_arready("bp_r1");
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_rvalid("bp_r1");
        araddr = 4'h4; arvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== 32'hCAFEF00D || arready !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_rhold%0d got rv %b d %h ar %b exp 1 cafef00d 0", i, rvalid, rdata, arready);
            end
        end
        @(posedge clk); #1; rready = 1'b1;
        @(posedge clk); #1; rready = 1'b0;
        wait_arready("bp_r2");
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        wait_rvalid("bp_r2");
        d0 = rdata;
        @(posedge clk); #1; rready = 1'b0;
        n_checks++;
        if (d0 !== 32'h11111111) begin
            n_errors++; $display("FAIL bp_read2 got %h exp 11111111", d0);
        end
    endtask

    task automatic test_collision();
        logic [1:0]  resp;
        logic [31:0] d;
        // reg2 still holds 0x3 from the basic test.
        @(posedge clk); #1;
        awaddr = 4'h8; wdata = 32'h000000A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'h8; arvalid = 1'b1;
        wait_awready("coll");
        n_checks++;
        if (arready !== 1'b1) begin
            n_errors++; $display("FAIL coll_align got arready %b exp 1", arready);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'h3) begin
            n_errors++;
            $display("FAIL coll_old got bv %b rv %b d %h exp 1 1 00000003", bvalid, rvalid, rdata);
        end
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        axi_read(4'h8, d, resp);
        n_checks++;
        if (d !== 32'hA5) begin
            n_errors++; $display("FAIL coll_new got %h exp 000000a5", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0]  resp;
        logic [31:0] d;
        @(posedge clk); #1;
        awaddr = 4'hC; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        wait_awready("rst_mid");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_bvalid("rst_mid");
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({awready, wready, bvalid, arready, rvalid, reg_wr, rdata} !== 41'h0 || regs !== 128'h0) begin
            n_errors++;
            $display("FAIL rst_mid_outs got bv %b regs %h exp 0", bvalid, regs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bvalid !== 1'b0) begin
                n_errors++; $display("FAIL rst_mid_nob%0d got %b exp 0", i, bvalid);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i*4), d, resp);
            n_checks++;
            if (d !== 32'h0) begin
                n_errors++; $display("FAIL rst_mid_read%0d got %h exp 0", i, d);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_aw_early();
        test_backpressure();
        test_collision();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/my_adcip_s00_axi_regs.md
# my_adcip_s00_axi_regs

AXI4-Lite slave register file for the ADC IP's S00_AXI port: the responder side of the master that configures the IP. It holds four 32-bit read/write registers, honours byte strobes, and returns OKAY responses. Register contents and per-register write pulses are exported to the ADC datapath. It sits between the IP's S00_AXI bus pins and the ADC control logic.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, address bus width; minimum 4.

Ports:
- S_AXI_ACLK  in  1  sole clock; all logic is on the rising edge.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address. S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1. S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  32. S_AXI_WSTRB  in  4. S_AXI_WVALID  in  1. S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2. S_AXI_BVALID  out  1. S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH. S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1. S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32. S_AXI_RRESP  out  2. S_AXI_RVALID  out  1. S_AXI_RREADY  in  1.
- regs_o  out  128  register contents; reg n occupies bits [32n+31:32n].
- reg_wr_o  out  4  one-cycle pulse, bit n, issued when reg n is written.

## Operation
- Register decode uses address bits [3:2]: reg0 at 0x0, reg1 at 0x4, reg2 at 0x8, reg3 at 0xC.
  - Bits [1:0] are ignored.
  - Bits above 3 are ignored, so the register map aliases across the address space.
- Write FSM, states W_IDLE, W_ACCEPT, W_RESP:
  - W_IDLE -> W_ACCEPT when AWVALID && WVALID are both high in the same cycle. A lone AWVALID or lone WVALID waits; the slave never accepts one channel without the other.
  - W_ACCEPT lasts exactly one cycle, with AWREADY = WREADY = 1.
  - At the end of W_ACCEPT, byte lane k of the addressed register takes WDATA[8k+7:8k] if WSTRB[k] is set, otherwise it keeps its value. That register's reg_wr_o bit is asserted.
  - W_ACCEPT -> W_RESP: BVALID = 1, BRESP = 2'b00. W_RESP -> W_IDLE on BREADY.
- Read FSM, states R_IDLE, R_ACCEPT, R_DATA:
  - R_IDLE -> R_ACCEPT on ARVALID.
  - R_ACCEPT lasts one cycle, with ARREADY = 1; RDATA is latched from the addressed register.
  - R_ACCEPT -> R_DATA: RVALID = 1, RRESP = 2'b00. RDATA is held stable until RREADY; then R_DATA -> R_IDLE.
- The two FSMs are independent, and each allows at most one outstanding transaction.
- Simultaneous events: if R_ACCEPT and W_ACCEPT fall in the same cycle on the same register, the read returns the pre-write value.
- Reset values (asynchronous on ARESETN low): every register, regs_o, reg_wr_o, all READY/VALID outputs, RDATA and the RESP outputs are 0; both FSMs are in IDLE.
- Reset mid-transaction abandons the transaction. No B or R response is issued after reset releases.

## Timing
- Write: AW and W both valid in cycle N:
  - AWREADY/WREADY high in N+1.
  - regs_o updated and reg_wr_o pulses in N+2.
  - BVALID high from N+2.
  - Earliest next AW/W acceptance is 2 cycles after BREADY is sampled.
- Read: ARVALID in cycle N -> ARREADY in N+1 -> RVALID with data in N+2.
- All outputs are registered; there is no combinational path from any input to any output.
- Throughput is one write per 3 cycles and one read per 3 cycles with READY held high; reads and writes run concurrently.

## Structure
- Shared package my_adcip_pkg holds:
  - wr_state_t and rd_state_t enums.
  - REG0_IDX..REG3_IDX and NUM_REGS = 4.
  - RESP_OKAY = 2'b00.
  - A function for byte-strobe merging.
- The block is a single module; no sub-module is warranted.

## Test plan
- After reset, write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read all four -> 0x1..0x4, every BRESP/RRESP = 0; reg_wr_o pulses 0001, 0010, 0100, 1000.
- Write 0xFFFFFFFF to 0x4, then 0x12345678 with WSTRB = 0101 -> read 0x4 returns 0xFF34FF78.
- AWVALID raised 5 cycles before WVALID -> AWREADY stays low until WVALID; a single acceptance follows; regs_o updates once.
- BREADY and RREADY held low 10 cycles -> BVALID/RVALID/RDATA stable; no new AW or AR accepted until the response is taken.
- Write 0xA5 to 0x8 with a read of 0x8 aligned so R_ACCEPT and W_ACCEPT coincide -> read returns the old value; the next read returns 0xA5.
- ARESETN pulsed low while BVALID is high -> all outputs 0 immediately; no BVALID after release; all registers read 0.
